// File: rtl/ofdm_pkg.sv
// Shared types and default constants for the OFDM QPSK mapper.
package ofdm_pkg;

  localparam int unsigned NUM_SC_DEF     = 64;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned IQ_WIDTH_DEF   = 8;
  localparam int unsigned AMP_DEF        = 90;
  localparam int unsigned IDX_W_DEF      = $clog2(NUM_SC_DEF);

  typedef enum logic {
    PAIR_EVEN = 1'b0,
    PAIR_ODD  = 1'b1
  } pair_state_t;

  typedef struct packed {
    logic signed [IQ_WIDTH_DEF-1:0] i;
    logic signed [IQ_WIDTH_DEF-1:0] q;
    logic [IDX_W_DEF-1:0]           idx;
    logic                           last;
  } sym_t;

endpackage

// File: rtl/ofdm_sym_fifo.sv
// Synchronous FIFO holding mapped symbols; head word is always presented on rdata.
module ofdm_sym_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             ofdm_clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge ofdm_clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < int'(DEPTH); k++) mem[k] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofdm_qpsk_mapper.sv
// Pairs serial cipher bits into QPSK symbols tagged with subcarrier index, buffered in a FIFO.
module ofdm_qpsk_mapper
  import ofdm_pkg::*;
#(
  parameter int unsigned NUM_SC     = NUM_SC_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned IQ_WIDTH   = IQ_WIDTH_DEF,
  parameter int unsigned AMP        = AMP_DEF
) (
  input  logic                          ofdm_clk,
  input  logic                          resetn,
  input  logic                          ofdm_sdata_vld,
  output logic                          ofdm_sdata_rdy,
  input  logic                          ofdm_sdata,
  output logic                          sym_vld,
  input  logic                          sym_rdy,
  output logic signed [IQ_WIDTH-1:0]    sym_i,
  output logic signed [IQ_WIDTH-1:0]    sym_q,
  output logic [$clog2(NUM_SC)-1:0]     sym_idx,
  output logic                          sym_last
);

  localparam int unsigned IDX_W = $clog2(NUM_SC);
  localparam int unsigned SYM_W = 2 * IQ_WIDTH + IDX_W + 1;
  localparam logic [IQ_WIDTH-1:0] POS_AMP = IQ_WIDTH'(AMP);
  localparam logic [IQ_WIDTH-1:0] NEG_AMP = IQ_WIDTH'(32'd0 - AMP);

  pair_state_t      state;
  logic             i_bit;
  logic [IDX_W-1:0] sc_cnt;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [SYM_W-1:0] wdata;
  logic [SYM_W-1:0] head;

  function automatic logic [IQ_WIDTH-1:0] qpsk_map(input logic b);
    return b ? NEG_AMP : POS_AMP;
  endfunction

  // Only the Q-bit phase can stall, so the I bit is always taken.
  assign ofdm_sdata_rdy = (state == PAIR_EVEN) | ~fifo_full;
  assign accept         = ofdm_sdata_vld & ofdm_sdata_rdy;
  assign push           = accept & (state == PAIR_ODD);
  assign pop            = sym_vld & sym_rdy;
  assign sym_vld        = ~fifo_empty;

  assign wdata = {qpsk_map(i_bit), qpsk_map(ofdm_sdata), sc_cnt,
                  (sc_cnt == IDX_W'(NUM_SC - 1))};
  assign {sym_i, sym_q, sym_idx, sym_last} = head;

  always_ff @(posedge ofdm_clk or negedge resetn) begin
    if (!resetn) begin
      state  <= PAIR_EVEN;
      i_bit  <= 1'b0;
      sc_cnt <= '0;
    end else if (accept) begin
      case (state)
        PAIR_EVEN: begin
          i_bit <= ofdm_sdata;
          state <= PAIR_ODD;
        end
        default: begin
          state  <= PAIR_EVEN;
          sc_cnt <= (sc_cnt == IDX_W'(NUM_SC - 1)) ? '0 : sc_cnt + IDX_W'(1);
        end
      endcase
    end
  end

  ofdm_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SYM_W)
  ) u_fifo (
    .ofdm_clk (ofdm_clk),
    .resetn   (resetn),
    .push     (push),
    .wdata    (wdata),
    .pop      (pop),
    .rdata    (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ofdm_qpsk_mapper.sv
// Random and directed stimulus for ofdm_qpsk_mapper against a queue-based symbol model.
module tb_ofdm_qpsk_mapper;
  import ofdm_pkg::*;

  localparam int NSC   = 64;
  localparam int DEPTH = 4;

  logic       ofdm_clk = 1'b0;
  logic       resetn   = 1'b0;
  logic       ofdm_sdata_vld = 1'b0;
  logic       ofdm_sdata_rdy;
  logic       ofdm_sdata = 1'b0;
  logic       sym_vld;
  logic       sym_rdy = 1'b0;
  logic signed [7:0] sym_i;
  logic signed [7:0] sym_q;
  logic [5:0] sym_idx;
  logic       sym_last;

  int checks   = 0;
  int failures = 0;
  int dut_pops = 0;
  int dut_lasts = 0;

  ofdm_qpsk_mapper dut (
    .ofdm_clk       (ofdm_clk),
    .resetn         (resetn),
    .ofdm_sdata_vld (ofdm_sdata_vld),
    .ofdm_sdata_rdy (ofdm_sdata_rdy),
    .ofdm_sdata     (ofdm_sdata),
    .sym_vld        (sym_vld),
    .sym_rdy        (sym_rdy),
    .sym_i          (sym_i),
    .sym_q          (sym_q),
    .sym_idx        (sym_idx),
    .sym_last       (sym_last)
  );

  always #5 ofdm_clk = ~ofdm_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of expected symbols, half-pair memory, subcarrier count.
  sym_t m_q[$];
  bit   m_have_i;
  bit   m_i;
  int   m_cnt;

  function automatic int amp_of(input bit b);
    return b ? -90 : 90;
  endfunction

  function automatic bit model_rdy();
    return !m_have_i || (m_q.size() < DEPTH);
  endfunction

  always @(posedge ofdm_clk) begin
    bit acc, pp;
    sym_t s;
    if (!resetn) begin
      m_q.delete();
      m_have_i = 0;
      m_i = 0;
      m_cnt = 0;
    end else begin
      acc = ofdm_sdata_vld && model_rdy();
      pp  = (m_q.size() > 0) && sym_rdy;
      if (pp) void'(m_q.pop_front());
      if (acc) begin
        if (!m_have_i) begin
          m_i = ofdm_sdata;
          m_have_i = 1;
        end else begin
          s.i    = 8'(amp_of(m_i));
          s.q    = 8'(amp_of(ofdm_sdata));
          s.idx  = 6'(m_cnt);
          s.last = (m_cnt == NSC - 1);
          m_q.push_back(s);
          m_cnt = (m_cnt + 1) % NSC;
          m_have_i = 0;
        end
      end
    end
    #1;
    if (resetn) begin
      chk("sdata_rdy", int'(ofdm_sdata_rdy), int'(model_rdy()));
      chk("sym_vld", int'(sym_vld), int'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("sym_i", int'(sym_i), int'(m_q[0].i));
        chk("sym_q", int'(sym_q), int'(m_q[0].q));
        chk("sym_idx", int'(sym_idx), int'(m_q[0].idx));
        chk("sym_last", int'(sym_last), int'(m_q[0].last));
        if (sym_vld && sym_rdy) begin
          dut_pops++;
          if (sym_last) dut_lasts++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge ofdm_clk);
    resetn = 1'b0;
    ofdm_sdata_vld = 1'b0;
    repeat (2) @(negedge ofdm_clk);
    resetn = 1'b1;
  endtask

  // Drives one bit for exactly one cycle; callers guarantee the mapper is ready.
  task automatic send_bit(input bit b);
    @(negedge ofdm_clk);
    ofdm_sdata_vld = 1'b1;
    ofdm_sdata     = b;
  endtask

  task automatic idle(input int n);
    @(negedge ofdm_clk);
    ofdm_sdata_vld = 1'b0;
    repeat (n) @(negedge ofdm_clk);
  endtask

  initial begin
    int acc_bits, vld_cycles;

    // Reset values
    #2;
    chk("rst_vld", int'(sym_vld), 0);
    chk("rst_i", int'(sym_i), 0);
    chk("rst_q", int'(sym_q), 0);
    chk("rst_idx", int'(sym_idx), 0);
    chk("rst_last", int'(sym_last), 0);
    chk("rst_rdy", int'(ofdm_sdata_rdy), 1);
    repeat (2) @(negedge ofdm_clk);
    resetn = 1'b1;

    // Bits 0,0 / 1,0 / 1,1 with literal expectations and one-cycle latency
    sym_rdy = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);
    chk("lat_before_q", int'(sym_vld), 0);
    @(negedge ofdm_clk);
    ofdm_sdata_vld = 1'b0;
    chk("d1_vld", int'(sym_vld), 1);
    chk("d1_i", int'(sym_i), 90);
    chk("d1_q", int'(sym_q), 90);
    chk("d1_idx", int'(sym_idx), 0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge ofdm_clk);
    ofdm_sdata_vld = 1'b0;
    chk("d2_i", int'(sym_i), -90);
    chk("d2_q", int'(sym_q), 90);
    chk("d2_idx", int'(sym_idx), 1);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge ofdm_clk);
    ofdm_sdata_vld = 1'b0;
    chk("d3_i_hex", int'(sym_i[7:0]), 'hA6);
    chk("d3_q_hex", int'(sym_q[7:0]), 'hA6);
    chk("d3_idx", int'(sym_idx), 2);
    idle(3);

    // 128 continuous bits, one full OFDM symbol
    do_reset();
    sym_rdy = 1'b1;
    dut_pops = 0;
    dut_lasts = 0;
    for (int k = 0; k < 128; k++) send_bit(1'($urandom_range(0, 1)));
    idle(4);
    chk("frame_syms", dut_pops, 64);
    chk("frame_lasts", dut_lasts, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge ofdm_clk);
    ofdm_sdata_vld = 1'b0;
    chk("wrap_idx", int'(sym_idx), 0);
    chk("wrap_q", int'(sym_q), -90);
    idle(3);

    // Backpressure: fill until the mapper stalls, then drain
    do_reset();
    sym_rdy = 1'b0;
    acc_bits = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ofdm_clk);
      ofdm_sdata_vld = 1'b1;
      ofdm_sdata = 1'($urandom_range(0, 1));
      if (ofdm_sdata_rdy) acc_bits++;
    end
    chk("bp_accepted", acc_bits, 9);
    chk("bp_rdy_low", int'(ofdm_sdata_rdy), 0);
    @(negedge ofdm_clk);
    ofdm_sdata_vld = 1'b0;
    sym_rdy = 1'b1;
    repeat (8) @(negedge ofdm_clk);
    chk("bp_drained", int'(sym_vld), 0);

    // Three entries queued, then push and pop on the same edge
    do_reset();
    sym_rdy = 1'b0;
    for (int k = 0; k < 7; k++) send_bit(1'($urandom_range(0, 1)));
    send_bit(1'b1);
    sym_rdy = 1'b1;
    @(negedge ofdm_clk);
    ofdm_sdata_vld = 1'b0;
    sym_rdy = 1'b0;
    vld_cycles = 0;
    @(negedge ofdm_clk);
    sym_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (sym_vld) vld_cycles++;
      @(negedge ofdm_clk);
    end
    chk("pp_occupancy", vld_cycles, 3);

    // Reset with a half pair and two symbols queued
    do_reset();
    sym_rdy = 1'b0;
    for (int k = 0; k < 5; k++) send_bit(1'($urandom_range(0, 1)));
    @(negedge ofdm_clk);
    ofdm_sdata_vld = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mr_vld", int'(sym_vld), 0);
    chk("mr_rdy", int'(ofdm_sdata_rdy), 1);
    @(negedge ofdm_clk);
    resetn = 1'b1;
    sym_rdy = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge ofdm_clk);
    ofdm_sdata_vld = 1'b0;
    chk("mr_idx", int'(sym_idx), 0);
    chk("mr_i", int'(sym_i), -90);
    chk("mr_q", int'(sym_q), 90);
    idle(3);

    // Random traffic on both sides
    for (int k = 0; k < 3000; k++) begin
      @(negedge ofdm_clk);
      ofdm_sdata_vld = 1'($urandom_range(0, 3) != 0);
      ofdm_sdata     = 1'($urandom_range(0, 1));
      sym_rdy        = 1'($urandom_range(0, 2) != 0);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
